// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined radix-4 mux tree.
//   RADIX / RADIX_LOG2 : fan-in of one tree level and its select width.
//   n_cand(level, l)   : candidates registered by tree level `level` of an l-level tree.
//   cand_base(lvl, l)  : candidate offset of bus level `lvl` inside the flattened candidate bus
//                        (bus level 0 is the raw input, bus level l is the single result).
//   sel_w_legal(sel_w) : select width must be even and at least 2.
package mux_tree_pkg;

  localparam int unsigned RADIX      = 4;
  localparam int unsigned RADIX_LOG2 = 2;

  function automatic int unsigned n_cand(input int unsigned level, input int unsigned l);
    return 32'd1 << (RADIX_LOG2 * (l - level - 1));
  endfunction

  // Sum of 4^(l-k) for k < lvl, in closed form.
  function automatic int unsigned cand_base(input int unsigned lvl, input int unsigned l);
    return ((32'd1 << (RADIX_LOG2 * (l + 1))) - (32'd1 << (RADIX_LOG2 * (l - lvl + 1)))) / 3;
  endfunction

  function automatic bit sel_w_legal(input int unsigned sel_w);
    return (sel_w >= 2) && (sel_w % 2 == 0);
  endfunction

endpackage

// File: rtl/mux4_stage.sv
// One level of the mux tree: N_OUT radix-4 muxes feeding a register stage with valid/ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   up_valid / up_ready : upstream handshake (up_ready = this stage can load)
//   up_cand, up_sel     : 4*N_OUT candidates and the full select carried with the item
//   dn_valid / dn_ready : downstream handshake
//   dn_cand, dn_sel     : registered N_OUT candidates and carried select
module mux4_stage
  import mux_tree_pkg::*;
#(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned LEVEL  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            up_valid,
  output logic                            up_ready,
  input  logic [RADIX*N_OUT*DATA_W-1:0]   up_cand,
  input  logic [SEL_W-1:0]                up_sel,
  output logic                            dn_valid,
  input  logic                            dn_ready,
  output logic [N_OUT*DATA_W-1:0]         dn_cand,
  output logic [SEL_W-1:0]                dn_sel
);

  localparam int unsigned SelLsb = RADIX_LOG2 * LEVEL;

  logic [RADIX_LOG2-1:0]     pick;
  logic [N_OUT*DATA_W-1:0]   mux_out;
  logic                      valid_q;
  logic [N_OUT*DATA_W-1:0]   cand_q;
  logic [SEL_W-1:0]          sel_q;

  assign pick = up_sel[SelLsb +: RADIX_LOG2];

  always_comb begin
    mux_out = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      mux_out[j*DATA_W +: DATA_W] = up_cand[(j*RADIX + 32'(pick))*DATA_W +: DATA_W];
    end
  end

  // Load whenever the register is empty or its content leaves this cycle.
  assign up_ready = !valid_q || dn_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cand_q  <= '0;
      sel_q   <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        cand_q <= mux_out;
        sel_q  <= up_sel;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_cand  = cand_q;
  assign dn_sel   = sel_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer (N = 2**SEL_W) built from SEL_W/2 radix-4 levels, one register
// per level, valid/ready on both sides. Latency is SEL_W/2 cycles, throughput 1 item/cycle.
//   clk, rst_n            : clock, synchronous active-low reset
//   scan                  : (MUX_TREE_SCAN_EN only) select from internal wrapping counter
//   in_valid / in_ready   : input handshake; in_ready is combinational and 0 during reset
//   in_data               : channel k at in_data[k*DATA_W +: DATA_W]
//   in_sel                : channel to select
//   out_valid / out_ready : output handshake
//   out_data, out_sel     : selected value and the select that produced it
// Optional feature macro: MUX_TREE_SCAN_EN.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef MUX_TREE_SCAN_EN
  input  logic                          scan,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(2**SEL_W)*DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]              in_sel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [SEL_W-1:0]              out_sel
);

  localparam int unsigned L      = SEL_W / 2;
  localparam int unsigned BusW   = DATA_W * cand_base(L + 1, L);

  if (!sel_w_legal(SEL_W)) begin : g_bad_sel_w
    $error("mux_tree_pipe: SEL_W must be even and >= 2");
  end

  // All tree levels share one flat bus; bus level i holds 4^(L-i) candidates.
  logic [BusW-1:0]  cand_bus;
  logic [L:0]       valid_v;
  logic [L:0]       ready_v;
  logic [SEL_W-1:0] sel_v [L+1];
  logic [SEL_W-1:0] sel_eff;

`ifdef MUX_TREE_SCAN_EN
  logic [SEL_W-1:0] scan_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (scan && in_valid && in_ready) begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign sel_eff = scan ? scan_cnt : in_sel;
`else
  assign sel_eff = in_sel;
`endif

  assign cand_bus[0 +: (2**SEL_W)*DATA_W] = in_data;
  assign sel_v[0]   = sel_eff;
  assign valid_v[0] = in_valid;
  assign ready_v[L] = out_ready;

  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int unsigned NOut     = n_cand(i, L);
    localparam int unsigned InBase   = DATA_W * cand_base(i, L);
    localparam int unsigned OutBase  = DATA_W * cand_base(i + 1, L);

    mux4_stage #(
      .DATA_W (DATA_W),
      .N_OUT  (NOut),
      .SEL_W  (SEL_W),
      .LEVEL  (i)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (valid_v[i]),
      .up_ready (ready_v[i]),
      .up_cand  (cand_bus[InBase +: RADIX*NOut*DATA_W]),
      .up_sel   (sel_v[i]),
      .dn_valid (valid_v[i+1]),
      .dn_ready (ready_v[i+1]),
      .dn_cand  (cand_bus[OutBase +: NOut*DATA_W]),
      .dn_sel   (sel_v[i+1])
    );
  end

  assign in_ready  = rst_n && ready_v[0];
  assign out_valid = valid_v[L];
  assign out_data  = cand_bus[DATA_W*cand_base(L, L) +: DATA_W];
  assign out_sel   = sel_v[L];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Randomised and directed bench for mux_tree_pipe: an 8-bit 16:1 instance checked every cycle
// against a queue model, plus a 1-bit 64:1 instance checked with literal expectations.
module tb_mux_tree_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned L  = 2;
  localparam int unsigned N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N*DW-1:0] in_data;
  logic [SW-1:0] in_sel, out_sel;
  logic [DW-1:0] out_data;
`ifdef MUX_TREE_SCAN_EN
  logic          scan;
`endif

  logic          w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [63:0]   w_in_data;
  logic [5:0]    w_in_sel, w_out_sel;
  logic [0:0]    w_out_data;

  mux_tree_pipe #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_TREE_SCAN_EN
    .scan      (scan),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  mux_tree_pipe #(.DATA_W(1), .SEL_W(6)) dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_TREE_SCAN_EN
    .scan      (1'b0),
`endif
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_data),
    .in_sel    (w_in_sel),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_data  (w_out_data),
    .out_sel   (w_out_sel)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    int            stamp;
  } item_t;

  item_t         q[$];
  logic [SW-1:0] scan_m;
  logic [DW-1:0] seen_data[$];
  logic [SW-1:0] seen_sel[$];
  int            seen_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an item presented in cycle k is visible from cycle k+L, oldest first;
  // the input side is blocked only when L items are in flight and the consumer stalls.
  always @(negedge clk) begin
    logic          exp_ready, exp_valid;
    logic [SW-1:0] s;
    item_t         it;
    exp_ready = rst_n && !(q.size() == L && !out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    exp_valid = 1'b0;
    if (armed) begin
      if (q.size() > 0) exp_valid = (cyc - q[0].stamp >= int'(L));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_sel", 32'(out_sel), 32'(q[0].sel));
      end
      if (out_valid === 1'b1 && out_ready && rst_n) begin
        seen_data.push_back(out_data);
        seen_sel.push_back(out_sel);
        seen_cyc.push_back(cyc);
      end
    end
    if (!rst_n) begin
      q.delete();
      scan_m = '0;
      armed  = 1'b1;
    end else if (armed) begin
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        s = in_sel;
`ifdef MUX_TREE_SCAN_EN
        if (scan) begin
          s      = scan_m;
          scan_m = scan_m + 1'b1;
        end
`endif
        it.data  = in_data[s*DW +: DW];
        it.sel   = s;
        it.stamp = cyc;
        q.push_back(it);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seen();
    seen_data.delete();
    seen_sel.delete();
    seen_cyc.delete();
  endtask

  task automatic ramp_data();
    for (int k = 0; k < int'(N); k++) in_data[k*DW +: DW] = 8'(8'h10 + k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_sel = '0; in_data = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_in_sel = '0; w_in_data = '0;
`ifdef MUX_TREE_SCAN_EN
    scan = 1'b0;
`endif
    ramp_data();

    // Reset state.
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single item latency.
    in_sel = 4'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'd2);
    chk("lat_out_data", 32'(out_data), 32'h19);
    chk("lat_out_sel", 32'(out_sel), 32'd9);
    repeat (3) tick();

    // Back-to-back sweep.
    clear_seen();
    for (int s = 0; s < 16; s++) begin
      in_sel = 4'(s); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("sweep_count", 32'(seen_data.size()), 32'd16);
    for (int i = 0; i < seen_data.size() && i < 16; i++) begin
      chk("sweep_data", 32'(seen_data[i]), 32'(8'h10 + i));
      chk("sweep_gapless", 32'(seen_cyc[i] - seen_cyc[0]), 32'(i));
    end

    // Backpressure from an empty pipe: exactly L accepts, then in_ready drops.
    clear_seen();
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_sel = 4'(3 + 2 * acc);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_count", 32'(seen_data.size()), 32'd2);
    if (seen_data.size() == 2) begin
      chk("bp_first", 32'(seen_data[0]), 32'h13);
      chk("bp_second", 32'(seen_data[1]), 32'h15);
    end

    // Reset with two items in flight.
    clear_seen();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd2;
    tick();
    in_sel = 4'd4;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    chk("midrst_no_stale", 32'(seen_data.size()), 32'd0);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_sel    = 4'($urandom);
      for (int k = 0; k < int'(N) / 4; k++) in_data[k*32 +: 32] = $urandom;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    ramp_data();

`ifdef MUX_TREE_SCAN_EN
    // Scan mode: counter drives the select and wraps.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_seen();
    scan = 1'b1; in_sel = 4'hF; in_valid = 1'b1;
    repeat (18) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("scan_count", 32'(seen_sel.size()), 32'd18);
    for (int i = 0; i < seen_sel.size() && i < 18; i++)
      chk("scan_sel", 32'(seen_sel[i]), 32'(i % 16));
    clear_seen();
    scan = 1'b0; in_sel = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("scan_off_count", 32'(seen_sel.size()), 32'd1);
    if (seen_sel.size() == 1) chk("scan_off_sel", 32'(seen_sel[0]), 32'd5);
`endif

    // Wide tree: 64 channels, one-hot channel 37, latency 3.
    w_in_data = 64'd1 << 37;
    w_in_valid = 1'b1; w_in_sel = 6'd37;
    @(negedge clk);
    chk("wide_in_ready", 32'(w_in_ready), 32'd1);
    tick();
    w_in_sel = 6'd36;
    tick();
    w_in_valid = 1'b0;
    @(negedge clk);
    chk("wide_early", 32'(w_out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("wide_v0", 32'(w_out_valid), 32'd1);
    chk("wide_d0", 32'(w_out_data), 32'd1);
    chk("wide_s0", 32'(w_out_sel), 32'd37);
    tick();
    @(negedge clk);
    chk("wide_v1", 32'(w_out_valid), 32'd1);
    chk("wide_d1", 32'(w_out_data), 32'd0);
    chk("wide_s1", 32'(w_out_sel), 32'd36);
    tick();
    @(negedge clk);
    chk("wide_v2", 32'(w_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
